// File: rtl/io_responder_if.sv
// CPU-side I/O bus between the processor's I/O block and a device responder.
// The master drives address, strobes and write data; the slave returns read
// data and the access acknowledge.
interface io_responder_if;
  logic [15:0] dir;
  logic        activarEntradaSalida;
  logic        escribirEntradaSalida;
  logic [7:0]  datoEscrito;
  logic [7:0]  datoLeido;
  logic        listo;

  modport master (
    output dir,
    output activarEntradaSalida,
    output escribirEntradaSalida,
    output datoEscrito,
    input  datoLeido,
    input  listo
  );

  modport slave (
    input  dir,
    input  activarEntradaSalida,
    input  escribirEntradaSalida,
    input  datoEscrito,
    output datoLeido,
    output listo
  );
endinterface

// File: rtl/io_responder.sv
// Device-side I/O responder: four output port registers, a 4-deep input FIFO,
// a one-byte output stream and a status register behind an 8-entry
// (aliased) register map. One register access per enable pulse.
//
// state | meaning
// IDLE  | waiting for enable with a matching page; the access happens on leaving
// HOLD  | access done, listo high until enable is sampled low
module io_responder #(
  parameter logic [7:0] PAGE = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  io_responder_if.slave     bus,
  output logic [7:0]        puerto0,
  output logic [7:0]        puerto1,
  output logic [7:0]        puerto2,
  output logic [7:0]        puerto3,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        access;
  logic        wr_acc, rd_acc;
  logic [2:0]  idx;
  logic [7:0]  rd_mux;
  logic [7:0]  dato_leido_q;
  logic [7:0]  fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        full, nonempty, push, pop;
  logic        overrun;
  logic        unused_addr;

  // Address bits [7:3] are deliberately not decoded, so registers alias.
  assign unused_addr = ^bus.dir[7:3];
  assign idx         = bus.dir[2:0];

  assign wr_acc   = access && bus.escribirEntradaSalida;
  assign rd_acc   = access && !bus.escribirEntradaSalida;

  assign full     = (count == 3'd4);
  assign nonempty = (count != 3'd0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  // An empty-FIFO read returns zero and must not move the read pointer.
  assign pop      = rd_acc && (idx == 3'd4) && nonempty;

  assign bus.listo     = (state == HOLD);
  assign bus.datoLeido = dato_leido_q;

  // Transaction state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; the access strobe fires only on the IDLE->HOLD edge.
  always_comb begin
    state_nxt = state;
    access    = 1'b0;
    case (state)
      IDLE: if (bus.activarEntradaSalida && (bus.dir[15:8] == PAGE)) begin
        state_nxt = HOLD;
        access    = 1'b1;
      end
      HOLD: if (!bus.activarEntradaSalida) state_nxt = IDLE;
    endcase
  end

  // Read data selection from pre-edge register values.
  always_comb begin
    rd_mux = 8'h00;
    case (idx)
      3'd0:    rd_mux = puerto0;
      3'd1:    rd_mux = puerto1;
      3'd2:    rd_mux = puerto2;
      3'd3:    rd_mux = puerto3;
      3'd4:    if (nonempty) rd_mux = fifo_mem[rd_ptr];
      3'd5:    rd_mux = {4'b0000, overrun, out_valid, full, nonempty};
      3'd6:    rd_mux = out_data;
      default: rd_mux = 8'h00;
    endcase
  end

  // Port register writes and read-data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      puerto0      <= 8'h00;
      puerto1      <= 8'h00;
      puerto2      <= 8'h00;
      puerto3      <= 8'h00;
      dato_leido_q <= 8'h00;
    end else begin
      if (wr_acc) begin
        case (idx)
          3'd0:    puerto0 <= bus.datoEscrito;
          3'd1:    puerto1 <= bus.datoEscrito;
          3'd2:    puerto2 <= bus.datoEscrito;
          3'd3:    puerto3 <= bus.datoEscrito;
          default: ;
        endcase
      end
      if (rd_acc) dato_leido_q <= rd_mux;
    end
  end

  // Input FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= 8'h00;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= in_data;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: ;
      endcase
    end
  end

  // Output stream and sticky overrun; busy is judged on pre-edge out_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (wr_acc && (idx == 3'd6)) begin
        if (out_valid) begin
          overrun <= 1'b1;
        end else begin
          out_data  <= bus.datoEscrito;
          out_valid <= 1'b1;
        end
      end else if (rd_acc && (idx == 3'd5)) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/io_responder.md
# io_responder

Device-side end of the processor's I/O interface. It decodes the 16-bit I/O address and the enable/write strobes driven by the CPU-side I/O block and performs one register access per transaction. It holds four 8-bit output port registers, a 4-deep input FIFO fed by an external device through a valid/ready handshake, and a one-byte output stream with a valid/ready handshake. Read data and an acknowledge go back to the CPU side.

## Interface

- `PAGE`, default 8'h00: value compared against `dir[15:8]` to select this block.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `dir` input 16: I/O address. `[15:8]` is the page and is compared with `PAGE`. `[2:0]` is the register index. `[7:3]` is ignored, so registers alias.
- `activarEntradaSalida` input 1: transaction enable, level.
- `escribirEntradaSalida` input 1: 1 = write, 0 = read.
- `datoEscrito` input 8: write data from the CPU side.
- `datoLeido` output 8: registered read data.
- `listo` output 1: access acknowledge.
- `puerto0`..`puerto3` output 8 each: output port registers.
- `in_data` input 8, `in_valid` input 1, `in_ready` output 1: device-to-CPU byte stream.
- `out_data` output 8, `out_valid` output 1, `out_ready` input 1: CPU-to-device byte stream.

## Operation

- Register map:
  - 0–3: `puerto0`..`puerto3`, read/write.
  - 4: input FIFO. Read pops the head. A read when the FIFO is empty returns 8'h00 and does not change the count. Writes are ignored.
  - 5: status, read-only: `{4'b0, overrun, out_valid, full, nonempty}`. A read clears `overrun` at the same edge.
  - 6: output stream. A write while `out_valid`=0 loads `out_data` and sets `out_valid`. A write while `out_valid`=1 is dropped and sets `overrun` (sticky). A read returns `out_data`.
  - 7: reserved. Reads return 8'h00; writes are ignored.
- Transaction FSM:
  - `IDLE` → `HOLD` at an edge where `activarEntradaSalida`=1 and `dir[15:8]`==`PAGE`. That edge performs the access: the write takes effect, or `datoLeido` is loaded with the pre-edge register value. `datoLeido` is unchanged on writes.
  - `HOLD` → `IDLE` at the first edge where `activarEntradaSalida`=0. Changes to address, data and write bit during `HOLD` are ignored, so exactly one access happens per enable pulse.
  - `listo` = (state == `HOLD`).
  - A non-matching page leaves the FSM in `IDLE` with no effect. If the address changes to a matching page while enable is still high, the access happens at that edge.
- Input FIFO:
  - 4 entries; 3-bit count from 0 to 4. `in_ready` = !full, derived combinationally from the count.
  - A push occurs at an edge with `in_valid`&&`in_ready`.
  - Simultaneous push and pop: the count is unchanged and order is preserved.
  - Pop while empty with a simultaneous push: returns 8'h00, and the pushed byte is stored.
  - When full, `in_ready`=0, so a same-edge pop does not admit a push. `in_ready` rises the cycle after the pop.
  - Read and write pointers are 2 bits and wrap modulo 4.
- Output stream:
  - `out_valid` clears at an edge with `out_valid`&&`out_ready`.
  - Busy status is evaluated from pre-edge `out_valid`. A write arriving at the same edge as the handshake completes is therefore dropped and sets `overrun`.

## Timing

- Reset values:
  - `puerto0`..`3` = 8'h00, `datoLeido` = 8'h00, `listo` = 0.
  - `out_data` = 8'h00, `out_valid` = 0, `overrun` = 0.
  - FIFO empty, so `in_ready` = 1. FSM in `IDLE`.
- Reset is asynchronous and applies immediately. If enable is still high with a matching page when `reset` is released, a new access occurs at the first edge.
- Access latency:
  - Enable is sampled high at edge k.
  - Writes are visible on the port outputs after k.
  - `datoLeido` is valid and `listo`=1 after k, and both hold until enable is sampled low.
  - `listo` falls after the edge at which enable is sampled low.
- Minimum spacing: the enable must be low for at least one edge between transactions.
- FIFO: data pushed at edge k is readable by an access at k+1 or later.
- `out_valid` rises the cycle after the write edge.

## Test plan

- Reset, then write 8'hA5 to address 16'h0002 and hold enable for 3 cycles → `puerto2`=8'hA5 one cycle later, `listo` high for 3 cycles, exactly one write; read-back of address 2 returns 8'hA5.
- Push 8'h11, 8'h22, 8'h33, 8'h44 → `in_ready`=0; status reads 8'h03. Four reads of address 4 return 11, 22, 33, 44; a fifth read returns 8'h00 and status reads 8'h00.
- FIFO full, read address 4 while `in_valid`=1 with `in_data`=8'h55 → no push that edge; `in_ready` rises next cycle; 8'h55 is accepted next and comes out after 22, 33, 44.
- Write 8'h7E to address 6 with `out_ready`=0, then write 8'h01 → `out_data` stays 7E; status reads 8'h0C and a second status read gives 8'h04; raising `out_ready` for one cycle clears `out_valid`.
- Access with `dir`=16'h0100 when `PAGE`=8'h00 → `listo` stays 0 and no register changes.
- Assert `reset` during `HOLD` after a write to address 1 → all outputs return to reset values immediately; after release with enable still high and address 1, the write is applied again.
